// File: rtl/cdcc_pkg.sv
// Shared constants and state type for the tap serialiser.
// Holds the tap count, default element width and the two-state FSM encoding.
package cdcc_pkg;

  localparam int TAPS      = 4;
  localparam int W_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/tap_serialiser.sv
// Serialises a parallel 4-tap window into one element per accepted output beat,
// oldest tap first, with zero-bubble reload when the next window is ready on the last tap.
module tap_serialiser
  import cdcc_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in_0,
  input  logic signed [W-1:0] in_1,
  input  logic signed [W-1:0] in_2,
  input  logic signed [W-1:0] in_3,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  state_t              state;
  logic [1:0]          idx;
  logic signed [W-1:0] win [TAPS];

  logic at_last;
  logic in_acc;
  logic out_acc;

  assign at_last = (idx == 2'd3);

  // A new window may only enter when idle, or when the last tap is leaving this cycle;
  // rst_n gates it so nothing is offered while the block is held in reset.
  assign in_ready  = rst_n && ((state == IDLE) || (at_last && out_ready));
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && at_last;
  assign out_data  = win[idx];
  assign out_idx   = idx;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      for (int i = 0; i < TAPS; i++) begin
        win[i] <= '0;
      end
    end else if (in_acc) begin
      win[0] <= in_0;
      win[1] <= in_1;
      win[2] <= in_2;
      win[3] <= in_3;
      idx    <= 2'd0;
      state  <= SEND;
    end else if (out_acc) begin
      if (at_last) begin
        state <= IDLE;
        idx   <= 2'd0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tap_serialiser.sv
// Directed, table-driven bench for tap_serialiser: each vector drives inputs after the
// falling edge and checks the outputs the block presents before the next rising edge.
module tb_tap_serialiser;

  localparam int W = 16;

  logic                clk;
  logic                rst_n;
  logic signed [W-1:0] in_0, in_1, in_2, in_3;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic [1:0]          out_idx;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  tap_serialiser #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_0      (in_0),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_3      (in_3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                iv;
    logic signed [W-1:0] a, b, c, d;
    logic                ordy;
    logic                ir;
    logic                ov;
    logic signed [W-1:0] od;
    logic [1:0]          oi;
    logic                ol;
    logic                chkd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mkv(input bit iv, input int a, input int b, input int c,
                               input int d, input bit ordy, input bit ir, input bit ov,
                               input int od, input int oi, input bit ol, input bit chkd);
    vec_t v;
    v.iv   = iv;
    v.a    = W'(a);
    v.b    = W'(b);
    v.c    = W'(c);
    v.d    = W'(d);
    v.ordy = ordy;
    v.ir   = ir;
    v.ov   = ov;
    v.od   = W'(od);
    v.oi   = 2'(oi);
    v.ol   = ol;
    v.chkd = chkd;
    return v;
  endfunction

  task automatic check_output(input vec_t v, input string tag);
    logic [W+4:0] got, want;
    got  = {in_ready, out_valid, out_idx, out_last, v.chkd ? out_data : {W{1'b0}}};
    want = {v.ir, v.ov, v.oi, v.ol, v.chkd ? v.od : {W{1'b0}}};
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got ir=%0b ov=%0b idx=%0d last=%0b data=%0d, want ir=%0b ov=%0b idx=%0d last=%0b data=%0d%s",
               tag, in_ready, out_valid, out_idx, out_last, out_data,
               v.ir, v.ov, v.oi, v.ol, v.od, v.chkd ? "" : " (data ignored)");
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = v.iv;
    in_0      = v.a;
    in_1      = v.b;
    in_2      = v.c;
    in_3      = v.d;
    out_ready = v.ordy;
    #1;
    check_output(v, tag);
  endtask

  initial begin
    vec_t rv;

    // Cycle-by-cycle script; inputs 111..444 are junk that must never be captured.
    // Single window with extreme values, then idle.
    tbl.push_back(mkv(1, -3, 7, 32767, -32768, 1, 1, 0,      0, 0, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     -3, 0, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,      7, 1, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,  32767, 2, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 1, -32768, 3, 1, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 0,      0, 0, 0, 0));
    // Back-to-back windows, second accepted alongside element 4.
    tbl.push_back(mkv(1, 1, 2, 3, 4,           1, 1, 0,      0, 0, 0, 0));
    tbl.push_back(mkv(1, 5, 6, 7, 8,           1, 0, 1,      1, 0, 0, 1));
    tbl.push_back(mkv(1, 5, 6, 7, 8,           1, 0, 1,      2, 1, 0, 1));
    tbl.push_back(mkv(1, 5, 6, 7, 8,           1, 0, 1,      3, 2, 0, 1));
    tbl.push_back(mkv(1, 5, 6, 7, 8,           1, 1, 1,      4, 3, 1, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,      5, 0, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,      6, 1, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,      7, 2, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 1,      8, 3, 1, 1));
    // Stall at idx 1 for three cycles with junk offered on the input side.
    tbl.push_back(mkv(1, 10, 20, 30, 40,       1, 1, 0,      0, 0, 0, 0));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     10, 0, 0, 1));
    tbl.push_back(mkv(1, 111, 222, 333, 444,   0, 0, 1,     20, 1, 0, 1));
    tbl.push_back(mkv(1, 111, 222, 333, 444,   0, 0, 1,     20, 1, 0, 1));
    tbl.push_back(mkv(1, 111, 222, 333, 444,   0, 0, 1,     20, 1, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     20, 1, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     30, 2, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 1,     40, 3, 1, 1));
    // Pending window held off by a stall on the last tap, then taken with no bubble.
    tbl.push_back(mkv(1, 11, 12, 13, 14,       1, 1, 0,      0, 0, 0, 0));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       1, 0, 1,     11, 0, 0, 1));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       1, 0, 1,     12, 1, 0, 1));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       1, 0, 1,     13, 2, 0, 1));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       0, 0, 1,     14, 3, 1, 1));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       0, 0, 1,     14, 3, 1, 1));
    tbl.push_back(mkv(1, 21, 22, 23, 24,       1, 1, 1,     14, 3, 1, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     21, 0, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     22, 1, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 0, 1,     23, 2, 0, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 1,     24, 3, 1, 1));
    tbl.push_back(mkv(0, 111, 222, 333, 444,   1, 1, 0,      0, 0, 0, 0));

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_0      = '0;
    in_1      = '0;
    in_2      = '0;
    in_3      = '0;
    out_ready = 1'b0;

    // Held in reset: everything zero and in_ready forced low.
    #2;
    check_output(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "reset_hold");
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Mid-window reset: advance {1,2,3,4} to idx 2, then pull rst_n low before the edge.
    apply_stimulus(mkv(1, 1, 2, 3, 4,         1, 1, 0, 0, 0, 0, 0), "rst_acc");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 1, 0, 0, 1), "rst_idx0");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 2, 1, 0, 1), "rst_idx1");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 3, 2, 0, 1), "rst_idx2");
    rst_n = 1'b0;
    #1;
    check_output(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "rst_async");
    @(posedge clk);
    #1;
    check_output(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "rst_held_edge");
    #1 rst_n = 1'b1;
    rv = mkv(1, 9, 9, 9, 9, 1, 1, 0, 0, 0, 0, 1);
    apply_stimulus(rv, "post_rst_ready");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 9, 0, 0, 1), "fresh0");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 9, 1, 0, 1), "fresh1");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 0, 1, 9, 2, 0, 1), "fresh2");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 1, 1, 9, 3, 1, 1), "fresh3");
    apply_stimulus(mkv(0, 111, 222, 333, 444, 1, 1, 0, 0, 0, 0, 0), "fresh_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
